// File: rtl/kernel_launch_queue.sv
// kernel_launch_queue: host-side launch controller in front of the block dispatcher.
// Buffers thread-count descriptors in a small FIFO and runs them one at a time
// (reset dispatcher, pulse start, wait for done). Optional per-kernel cycle
// counter is built when KLQ_CYCLE_COUNT_EN is defined; otherwise
// last_kernel_cycles reads as zero.
`timescale 1ns/1ps

module kernel_launch_queue #(
    parameter int DEPTH             = 4,
    parameter int THREAD_COUNT_BITS = 8,
    parameter int COUNT_BITS        = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [THREAD_COUNT_BITS-1:0]  wr_thread_count,
    output logic                          wr_ready,
    input  logic                          abort,
    output logic                          dispatch_reset,
    output logic                          dispatch_start,
    output logic [THREAD_COUNT_BITS-1:0]  dispatch_thread_count,
    input  logic                          dispatch_done,
    output logic                          busy,
    output logic [$clog2(DEPTH):0]        queue_level,
    output logic [COUNT_BITS-1:0]         launches_done,
    output logic [31:0]                   last_kernel_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RST   = 2'd1;
    localparam logic [1:0] S_START = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [THREAD_COUNT_BITS-1:0] mem_q [DEPTH];

    logic [1:0]                   state_q, state_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                count_q, count_d;
    logic                         disp_rst_q, disp_rst_d;
    logic                         disp_start_q, disp_start_d;
    logic [THREAD_COUNT_BITS-1:0] disp_tc_q, disp_tc_d;
    logic                         busy_q, busy_d;
    logic [COUNT_BITS-1:0]        done_cnt_q, done_cnt_d;

    logic                         push;
    logic                         pop;
    logic [THREAD_COUNT_BITS-1:0] head;

    assign wr_ready = (count_q != LW'(DEPTH));
    assign push     = wr_valid && wr_ready && !abort;
    assign head     = mem_q[rd_ptr_q];

    assign dispatch_reset        = disp_rst_q;
    assign dispatch_start        = disp_start_q;
    assign dispatch_thread_count = disp_tc_q;
    assign busy                  = busy_q;
    assign queue_level           = count_q;
    assign launches_done         = done_cnt_q;

    // Descriptor storage; written on every accepted host transfer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_thread_count;
        end
    end

    // Launch FSM, FIFO bookkeeping and registered output next-state.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        disp_tc_d    = disp_tc_q;
        done_cnt_d   = done_cnt_q;
        disp_rst_d   = 1'b0;
        disp_start_d = 1'b0;
        busy_d       = 1'b0;
        pop          = 1'b0;

        if (abort) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            state_d    = S_IDLE;
            disp_rst_d = (state_q != S_IDLE);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                        if (head != '0) begin
                            disp_tc_d = head;
                            state_d   = S_RST;
                        end else begin
                            // Zero-thread kernels retire without touching the dispatcher.
                            done_cnt_d = done_cnt_q + COUNT_BITS'(1);
                        end
                    end
                end
                S_RST:   state_d = S_START;
                S_START: state_d = S_RUN;
                default: begin
                    if (dispatch_done) begin
                        done_cnt_d = done_cnt_q + COUNT_BITS'(1);
                        state_d    = S_IDLE;
                    end
                end
            endcase

            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase

            // Outputs are registered from the next state so they line up with it.
            disp_rst_d   = (state_d == S_RST);
            disp_start_d = (state_d == S_START);
            busy_d       = (state_d != S_IDLE);
        end
    end

    // State and output registers; dispatcher held in reset while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            disp_rst_q   <= 1'b1;
            disp_start_q <= 1'b0;
            disp_tc_q    <= '0;
            busy_q       <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            disp_rst_q   <= disp_rst_d;
            disp_start_q <= disp_start_d;
            disp_tc_q    <= disp_tc_d;
            busy_q       <= busy_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

`ifdef KLQ_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] last_q, last_d;
    logic [31:0] cyc_inc;

    assign cyc_inc            = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
    assign last_kernel_cycles = last_q;

    // Kernel cycle counter: START loads 1, each RUN cycle adds one (saturating);
    // the value including the done cycle is captured on completion.
    always_comb begin
        cyc_d  = cyc_q;
        last_d = last_q;
        if (abort) begin
            cyc_d = '0;
        end else if (state_q == S_START) begin
            cyc_d = 32'd1;
        end else if (state_q == S_RUN) begin
            if (dispatch_done) begin
                last_d = cyc_inc;
            end else begin
                cyc_d = cyc_inc;
            end
        end
    end

    // Cycle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q  <= '0;
            last_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            last_q <= last_d;
        end
    end
`else
    assign last_kernel_cycles = '0;
`endif

endmodule

// File: tb/tb_kernel_launch_queue.sv
// Self-checking bench for kernel_launch_queue: a dispatcher model answers
// start pulses with done, and a scoreboard of launched thread counts is
// checked against every dispatch_start.
`timescale 1ns/1ps

module tb_kernel_launch_queue;

    localparam int DEPTH = 4;
    localparam int TCB   = 8;
    localparam int CB    = 8;

`ifdef KLQ_CYCLE_COUNT_EN
    localparam int LKC_EXP = 7;
`else
    localparam int LKC_EXP = 0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_valid;
    logic [TCB-1:0] wr_thread_count;
    logic           wr_ready;
    logic           abort;
    logic           dispatch_reset;
    logic           dispatch_start;
    logic [TCB-1:0] dispatch_thread_count;
    logic           dispatch_done;
    logic           busy;
    logic [2:0]     queue_level;
    logic [CB-1:0]  launches_done;
    logic [31:0]    last_kernel_cycles;

    logic model_done;
    logic extra_done;
    assign dispatch_done = model_done | extra_done;

    always #5 clk = ~clk;

    kernel_launch_queue #(
        .DEPTH(DEPTH),
        .THREAD_COUNT_BITS(TCB),
        .COUNT_BITS(CB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_valid(wr_valid),
        .wr_thread_count(wr_thread_count),
        .wr_ready(wr_ready),
        .abort(abort),
        .dispatch_reset(dispatch_reset),
        .dispatch_start(dispatch_start),
        .dispatch_thread_count(dispatch_thread_count),
        .dispatch_done(dispatch_done),
        .busy(busy),
        .queue_level(queue_level),
        .launches_done(launches_done),
        .last_kernel_cycles(last_kernel_cycles)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int exp_ld = 0;
    bit stall  = 1'b0;
    int done_delay = 6;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one descriptor, holding wr_valid until accepted (bounded).
    task automatic write(input int tc);
        bit ok;
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_thread_count = tc[TCB-1:0];
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        check("wr_accept", 32'(ok), 1);
        if (ok && tc != 0) exp_q.push_back(tc);
    endtask

    task automatic wait_launches(input int target);
        for (int i = 0; i < 400; i++) begin
            if (launches_done == target[CB-1:0] && !busy && queue_level == 0) break;
            tick();
        end
        check("launches_done", launches_done, target[CB-1:0]);
        check("busy_idle", busy, 0);
    endtask

    // Dispatcher model and start-pulse scoreboard.
    initial begin : monitor
        bit prev_rst;
        bit active;
        int ctr;
        int expv;
        prev_rst   = 1'b1;
        active     = 1'b0;
        ctr        = 0;
        model_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dispatch_start) begin
                check("rst_before_start", 32'(prev_rst), 1);
                check("start_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    expv = exp_q.pop_front();
                    check("start_thread_count", dispatch_thread_count, expv);
                end
            end
            if (reset || dispatch_reset) begin
                model_done = 1'b0;
                active     = 1'b0;
            end else if (dispatch_start) begin
                active = 1'b1;
                ctr    = done_delay;
            end else if (active) begin
                if (ctr > 0) ctr--;
                if (ctr == 0 && !stall) begin
                    model_done = 1'b1;
                    active     = 1'b0;
                end
            end
            prev_rst = dispatch_reset;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset = 1'b1;
        wr_valid = 1'b0;
        wr_thread_count = '0;
        abort = 1'b0;
        extra_done = 1'b0;

        // Reset values
        #2;
        check("rst_dispatch_reset", dispatch_reset, 1);
        check("rst_start", dispatch_start, 0);
        check("rst_busy", busy, 0);
        check("rst_level", queue_level, 0);
        check("rst_launches", launches_done, 0);
        check("rst_tc", dispatch_thread_count, 0);
        check("rst_lkc", last_kernel_cycles, 0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("rel_dispatch_reset_held", dispatch_reset, 1);
        tick();
        check("rel_dispatch_reset_drop", dispatch_reset, 0);
        check("rel_wr_ready", wr_ready, 1);

        // Single launch
        write(10);
        check("t1_level", queue_level, 1);
        check("t1_no_rst_yet", dispatch_reset, 0);
        tick();
        check("t1_rst", dispatch_reset, 1);
        check("t1_busy", busy, 1);
        check("t1_level_pop", queue_level, 0);
        check("t1_tc", dispatch_thread_count, 10);
        check("t1_no_start", dispatch_start, 0);
        tick();
        check("t1_start", dispatch_start, 1);
        check("t1_rst_off", dispatch_reset, 0);
        tick();
        check("t1_start_once", dispatch_start, 0);
        exp_ld = 1;
        wait_launches(exp_ld);
        check("t1_lkc", last_kernel_cycles, LKC_EXP);

        // Back-to-back
        write(10);
        check("t2_level_a", queue_level, 1);
        write(4);
        check("t2_level_b", queue_level, 1);
        write(16);
        check("t2_level_peak", queue_level, 2);
        exp_ld += 3;
        wait_launches(exp_ld);
        check("t2_lkc", last_kernel_cycles, LKC_EXP);

        // Full FIFO with the kernel stalled in RUN
        stall = 1'b1;
        write(7);
        repeat (4) tick();
        check("t3_busy", busy, 1);
        for (int v = 1; v <= 4; v++) write(v);
        check("t3_full_level", queue_level, 4);
        check("t3_full_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_thread_count = 8'd5;
        repeat (3) tick();
        check("t3_full_hold", queue_level, 4);
        stall = 1'b0;
        write(5);
        check("t3_refill_level", queue_level, 4);
        exp_ld += 6;
        wait_launches(exp_ld);

        // Zero-thread descriptor
        write(0);
        check("t4_level", queue_level, 1);
        write(3);
        check("t4_zero_retired", launches_done, exp_ld + 1);
        check("t4_zero_no_busy", busy, 0);
        check("t4_level_b", queue_level, 1);
        exp_ld += 2;
        wait_launches(exp_ld);

        // Abort in IDLE with an empty queue does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_idle_abort_rst", dispatch_reset, 0);
        check("t5_idle_abort_busy", busy, 0);
        check("t5_idle_abort_ld", launches_done, exp_ld);

        // Abort with one kernel running and three queued
        stall = 1'b1;
        write(9);
        repeat (3) tick();
        for (int v = 1; v <= 3; v++) write(v);
        check("t5_level", queue_level, 3);
        check("t5_busy", busy, 1);
        abort = 1'b1;
        wr_valid = 1'b1;
        wr_thread_count = 8'd55;
        tick();
        abort = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        check("t5_flush", queue_level, 0);
        check("t5_abort_rst", dispatch_reset, 1);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_ld", launches_done, exp_ld);
        tick();
        check("t5_abort_rst_once", dispatch_reset, 0);
        check("t5_write_dropped", queue_level, 0);
        stall = 1'b0;
        extra_done = 1'b1;
        repeat (4) tick();
        extra_done = 1'b0;
        check("t5_done_ignored", launches_done, exp_ld);
        check("t5_still_idle", busy, 0);
        check("t5_lkc_kept", last_kernel_cycles, LKC_EXP);

        // Asynchronous reset mid-RUN
        stall = 1'b1;
        write(8);
        repeat (3) tick();
        check("t6_busy", busy, 1);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_dispatch_reset", dispatch_reset, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ld", launches_done, 0);
        check("t6_rst_tc", dispatch_thread_count, 0);
        check("t6_rst_lkc", last_kernel_cycles, 0);
        exp_q.delete();
        exp_ld = 0;
        stall = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("t6_rel_held", dispatch_reset, 1);
        tick();
        check("t6_rel_drop", dispatch_reset, 0);
        write(20);
        exp_ld = 1;
        wait_launches(exp_ld);

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kernel_launch_queue.md
Name: kernel_launch_queue

Overview:
- Host-facing launch controller directly upstream of the block dispatcher.
- Buffers kernel launch descriptors (total thread count) in a small FIFO.
- Runs them one at a time: resets the dispatcher, pulses its start, holds thread_count stable, and waits for its done.
- Reports queue occupancy, busy status and a completed-launch counter to the host/status registers.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- THREAD_COUNT_BITS, 8, width of a launch descriptor (matches dispatcher thread_count)
- COUNT_BITS, 8, width of launches_done counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- wr_valid  in  1  host offers a descriptor
- wr_thread_count  in  THREAD_COUNT_BITS  total threads for the kernel
- wr_ready  out  1  FIFO can accept; transfer when wr_valid && wr_ready
- abort  in  1  synchronous flush and kill of the current kernel
- dispatch_reset  out  1  reset to dispatcher and cores
- dispatch_start  out  1  one-cycle start pulse to dispatcher
- dispatch_thread_count  out  THREAD_COUNT_BITS  held stable for the whole kernel
- dispatch_done  in  1  dispatcher done; may stay high until dispatch_reset
- busy  out  1  kernel in flight (state != IDLE)
- queue_level  out  clog2(DEPTH)+1  FIFO occupancy
- launches_done  out  COUNT_BITS  completed kernels; wraps modulo 2^COUNT_BITS
- last_kernel_cycles  out  32  see Optional Feature

Behaviour:
- Reset values:
  - dispatch_reset=1, released on the first clock after reset deasserts.
  - dispatch_start=0, dispatch_thread_count=0, busy=0, queue_level=0, launches_done=0, last_kernel_cycles=0.
  - State IDLE.
- wr_ready = (queue_level != DEPTH), combinational from registered count.
  - A write when full is ignored.
  - There is no bypass: a descriptor written in cycle N is first visible to IDLE in cycle N+1.
- A simultaneous push and pop updates the count by 0.
  - When full, wr_ready is still 0 in the pop cycle and becomes 1 the next cycle.
- All dispatch_* outputs, busy, queue_level and launches_done are registered.
- FSM:
  - IDLE:
    - Queue non-empty with head thread_count != 0: pop, latch head into dispatch_thread_count, go RST.
    - Queue non-empty with head == 0: pop, increment launches_done, stay IDLE. No dispatcher activity.
    - dispatch_done is ignored in IDLE.
  - RST: dispatch_reset=1 for exactly one cycle, then go START.
  - START: dispatch_start=1 for exactly one cycle, then go RUN.
  - RUN:
    - Wait for dispatch_done=1.
    - On done: increment launches_done and go IDLE.
    - The next launch can begin the following cycle.
    - dispatch_thread_count is unchanged throughout RUN.
- Minimum launch-to-launch spacing: 3 cycles plus dispatcher latency.
- abort, highest priority, any state:
  - Flush the FIFO (queue_level=0 next cycle).
  - If not IDLE: assert dispatch_reset for one cycle and go IDLE, without incrementing launches_done.
  - A host write in the same cycle as abort is dropped.
  - abort in IDLE with an empty queue has no effect.
- Asynchronous reset mid-kernel: immediate return to reset values; in-flight and queued launches are lost.
- FIFO pointers wrap modulo DEPTH; occupancy is tracked by count, not pointer comparison.

Optional Feature:
- Macro: KLQ_CYCLE_COUNT_EN
- Defined:
  - A 32-bit counter clears in START and increments each RUN cycle.
  - On dispatch_done in RUN, the counter value (START cycle counts as 1) loads into last_kernel_cycles.
  - The counter saturates at 2^32-1.
  - On abort the counter clears and last_kernel_cycles is not updated.
- Not defined: last_kernel_cycles is tied to 0 and no counter logic exists.

Test Plan:
- Single launch: write 10 → 1 cycle later RST (dispatch_reset=1), then START pulse with dispatch_thread_count=10; done asserted 6 cycles after start → launches_done=1, busy=0; with the macro, last_kernel_cycles=7.
- Back-to-back: write 10, 4, 16 in consecutive cycles → three launches in order with thread counts 10, 4, 16; each preceded by a one-cycle dispatch_reset; launches_done=3; queue_level peaks at 2 (one popped at arrival + 1).
- Full FIFO: with the kernel stalled in RUN, write 5 descriptors with DEPTH=4 → 4 accepted (queue_level=4, wr_ready=0); the 5th stays pending while wr_valid held and is accepted 1 cycle after the next pop.
- Zero-thread descriptor: write 0 then 3 → first retires in IDLE with no dispatch_start, launches_done=1; second launches normally with thread_count 3.
- Abort: 3 queued, one in RUN; pulse abort → queue_level=0, one-cycle dispatch_reset, state IDLE, launches_done unchanged, later dispatch_done ignored.
- Async reset mid-RUN: assert reset between clock edges → outputs at reset values immediately; dispatch_reset=1 until the first clock after release.
